// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_e : fetch FSM encoding
//   pc_sel_e      : next-pc source select driven by the FSM datapath
package instr_fetch_unit_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int unsigned PC_INCR        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_KEEP  = 2'd0,
    PC_SEL_INCR  = 2'd1,
    PC_SEL_REDIR = 2'd2,
    PC_SEL_PEND  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Combinational next-pc select for the fetch unit.
//   pc, redirect_pc, pending_pc : candidate sources
//   sel                         : which source feeds the next pc
//   redirect_aligned_c          : redirect_pc with bits [1:0] cleared
//   next_pc_c                   : selected next pc
module fetch_pc_next
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic [ADDR_WIDTH-1:0] pending_pc,
  input  pc_sel_e               sel,
  output logic [ADDR_WIDTH-1:0] redirect_aligned_c,
  output logic [ADDR_WIDTH-1:0] next_pc_c
);

  // Instructions are word aligned; low address bits of a target are dropped.
  assign redirect_aligned_c = redirect_pc & ~ADDR_WIDTH'(3);

  always_comb begin
    next_pc_c = pc;
    case (sel)
      PC_SEL_INCR:  next_pc_c = pc + ADDR_WIDTH'(PC_INCR);  // wraps silently
      PC_SEL_REDIR: next_pc_c = redirect_aligned_c;
      PC_SEL_PEND:  next_pc_c = pending_pc;
      default:      next_pc_c = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a variable-latency
// instruction memory and hands instructions to decode over valid/ready.
// Redirects from execute restart fetch; in-flight responses for the old
// path are discarded so decode never sees a stale instruction.
//   clk, rst                  : clock, async active-high reset
//   imem_req/addr/ack/rdata   : instruction memory request/response
//   redirect_valid/pc         : restart fetch at a new target
//   instr_valid/ready/instr/instr_pc : decode handshake
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned            ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pending_pc_q, pending_pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;
  pc_sel_e               pc_sel;
  logic [ADDR_WIDTH-1:0] redirect_aligned;

  fetch_pc_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_next (
    .pc                 (pc_q),
    .redirect_pc        (redirect_pc),
    .pending_pc         (pending_pc_q),
    .sel                (pc_sel),
    .redirect_aligned_c (redirect_aligned),
    .next_pc_c          (pc_d)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pending_pc_q  <= RESET_PC;
      instr_q       <= DATA_WIDTH'(NOP_INSTR);
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_pc_q  <= pending_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack && !redirect_valid)      state_d = HOLD;
        else if (!imem_ack && redirect_valid) state_d = DROP;
      end
      DROP: if (imem_ack) state_d = REQ;
      HOLD: if (redirect_valid || instr_ready) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: pc select, pending redirect, decode-side registers.
  always_comb begin
    pc_sel        = PC_SEL_KEEP;
    pending_pc_d  = pending_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      // A redirect during the dead cycle still steers the first fetch.
      IDLE: if (redirect_valid) pc_sel = PC_SEL_REDIR;
      REQ: begin
        if (imem_ack && redirect_valid) begin
          pc_sel = PC_SEL_REDIR;
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_sel        = PC_SEL_INCR;
        end else if (redirect_valid) begin
          // Address must stay put while the request is outstanding.
          pending_pc_d = redirect_aligned;
        end
      end
      DROP: begin
        if (imem_ack) pc_sel = redirect_valid ? PC_SEL_REDIR : PC_SEL_PEND;
        else if (redirect_valid) pending_pc_d = redirect_aligned;
      end
      HOLD: begin
        // Redirect wins over ready: the held instruction is squashed.
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          pc_sel        = PC_SEL_REDIR;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
        end
      end
      default: pc_sel = PC_SEL_KEEP;
    endcase
  end

  // Memory request decode from registered state.
  always_comb begin
    imem_req  = (state_q == REQ) || (state_q == DROP);
    imem_addr = pc_q;
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int total = 0;
  int bad   = 0;
  int lat   = 1;      // cycles imem_req is held, including the ack cycle
  int wait_cnt;
  logic [31:0] exp_q[$];
  logic [31:0] held_instr;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Memory model: acks after lat cycles of a held request, drops on rst.
  always @(posedge clk or posedge rst) begin
    if (rst)                      wait_cnt <= 0;
    else if (imem_req && imem_ack) wait_cnt <= 0;
    else if (imem_req)            wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack   = imem_req && (wait_cnt == lat - 1);
  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the next scoreboard entry and compare against the presented instruction.
  task automatic expect_instr(input string tag);
    logic [31:0] epc;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
      return;
    end
    epc = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, instr_pc, epc);
    chk({tag, "_instr"}, instr, mem_word(epc));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Assert reset at a negedge, release it at a later negedge (IDLE cycle next).
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    lat = 1;
    step();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);

    // Zero-latency memory, ready high: one instruction every two cycles.
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    chk("t1_idle_req", 32'(imem_req), 32'd0);
    step();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      expect_instr("t1_deliver");
      step();
      chk("t1_gap_valid", 32'(instr_valid), 32'd0);
    end

    // Three-cycle latency: address held while waiting.
    lat = 3;
    do_reset();
    exp_q.push_back(32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_req", 32'(imem_req), 32'd1);
      chk("t2_addr", imem_addr, 32'h0);
      chk("t2_valid", 32'(instr_valid), 32'd0);
    end
    step();
    expect_instr("t2_deliver");

    // Back-pressure: decode stalls for five cycles.
    instr_ready = 1'b0;
    held_instr = instr;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_valid", 32'(instr_valid), 32'd1);
      chk("t3_pc", instr_pc, 32'h0);
      chk("t3_instr", instr, held_instr);
      chk("t3_req", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    lat = 1;
    step();
    chk("t3_next_req", 32'(imem_req), 32'd1);
    chk("t3_next_addr", imem_addr, 32'h4);

    // Redirect while a request is outstanding: old response dropped.
    lat = 2;
    do_reset();
    step();
    chk("t4_addr0", imem_addr, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    exp_q.push_back(32'h100);
    step();
    redirect_valid = 1'b0;
    chk("t4_drop_req", 32'(imem_req), 32'd1);
    chk("t4_drop_addr", imem_addr, 32'h0);
    chk("t4_drop_ack", 32'(imem_ack), 32'd1);
    step();
    chk("t4_discard_valid", 32'(instr_valid), 32'd0);
    chk("t4_new_addr", imem_addr, 32'h100);
    step();
    chk("t4_wait_valid", 32'(instr_valid), 32'd0);
    step();
    expect_instr("t4_deliver");

    // Redirect in HOLD beats instr_ready.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    exp_q.push_back(32'h40);
    step();
    redirect_valid = 1'b0;
    chk("t5_valid_fall", 32'(instr_valid), 32'd0);
    chk("t5_addr", imem_addr, 32'h40);
    step();
    step();
    expect_instr("t5_deliver");

    // PC wrap at the top of the address space.
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC);
    step();
    redirect_valid = 1'b0;
    chk("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    expect_instr("t5_top_deliver");
    step();
    chk("t5_wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset during an outstanding request at 0x8.
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    step();
    step();
    expect_instr("t6_d0");
    step();
    step();
    expect_instr("t6_d1");
    lat = 4;
    step();
    chk("t6_out_addr", imem_addr, 32'h8);
    chk("t6_out_req", 32'(imem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_req", 32'(imem_req), 32'd0);
    chk("t6_async_valid", 32'(instr_valid), 32'd0);
    chk("t6_async_pc", instr_pc, 32'h0);
    chk("t6_async_addr", imem_addr, 32'h0);
    lat = 1;
    step();
    rst = 1'b0;
    exp_q.push_back(32'h0);
    chk("t6_idle_req", 32'(imem_req), 32'd0);
    step();
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", imem_addr, 32'h0);
    step();
    expect_instr("t6_deliver");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
